// File: rtl/key_pkg.sv
// Shared definitions for the key debounce array: FSM state encoding,
// synchroniser depth and width helpers used to size the per-channel counters.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_FILT = 2'd1,
      DOWN       = 2'd2,
      REL_FILT   = 2'd3
   } key_fsm_e;

   localparam int SYNC_STAGES = 2;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int f_cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int f_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One debounce channel: 2-FF synchroniser, press/release filter FSM with its
// stability counter, and the optional hold-to-repeat counter (KEY_REPEAT_EN).
module key_debounce_chan
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1000,
   parameter int ACTIVE_LOW   = 1,
   parameter int HOLD_CYC     = 25_000_000,
   parameter int REPEAT_CYC   = 5_000_000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_key,
   output logic o_p_flag,
   output logic o_r_flag,
   output logic o_state,
   output logic o_rep_flag
);

   localparam logic                 IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
   localparam int                   CNT_W    = f_cnt_w(DEBOUNCE_CYC);
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_pressed;
   key_fsm_e               r_st;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_p_flag;
   logic                   r_r_flag;
   logic                   r_state;

   // Bring the raw pin into the clock domain; reset value is the released level
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= {SYNC_STAGES{IDLE_LVL}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_key};
      end
   end

   assign w_pressed = r_sync[SYNC_STAGES-1] ^ IDLE_LVL;

   // Filter FSM: a level must hold for DEBOUNCE_CYC cycles before it is accepted
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_st     <= IDLE;
         r_cnt    <= '0;
         r_p_flag <= 1'b0;
         r_r_flag <= 1'b0;
         r_state  <= 1'b0;
      end else begin
         r_p_flag <= 1'b0;
         r_r_flag <= 1'b0;
         case (r_st)
            IDLE: begin
               if (w_pressed) begin
                  r_st  <= PRESS_FILT;
                  r_cnt <= '0;
               end
            end
            PRESS_FILT: begin
               if (!w_pressed) begin
                  r_st  <= IDLE;
                  r_cnt <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_st     <= DOWN;
                  r_cnt    <= '0;
                  r_p_flag <= 1'b1;
                  r_state  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            DOWN: begin
               if (!w_pressed) begin
                  r_st  <= REL_FILT;
                  r_cnt <= '0;
               end
            end
            REL_FILT: begin
               if (w_pressed) begin
                  // bounce while releasing: the key is still considered held
                  r_st  <= DOWN;
                  r_cnt <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_st     <= IDLE;
                  r_cnt    <= '0;
                  r_r_flag <= 1'b1;
                  r_state  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_st  <= IDLE;
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign o_p_flag = r_p_flag;
   assign o_r_flag = r_r_flag;
   assign o_state  = r_state;

`ifdef KEY_REPEAT_EN
   localparam int               REP_W     = f_cnt_w(f_max(HOLD_CYC, REPEAT_CYC));
   localparam logic [REP_W-1:0] HOLD_LAST = REP_W'(HOLD_CYC - 1);
   localparam logic [REP_W-1:0] REP_LAST  = REP_W'(REPEAT_CYC - 1);

   logic [REP_W-1:0] r_rcnt;
   logic             r_rphase;
   logic             r_rep_flag;

   // Hold-to-repeat: first pulse after HOLD_CYC, then every REPEAT_CYC while held
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rcnt     <= '0;
         r_rphase   <= 1'b0;
         r_rep_flag <= 1'b0;
      end else begin
         r_rep_flag <= 1'b0;
         if (r_st == DOWN || r_st == REL_FILT) begin
            if (r_rcnt == (r_rphase ? REP_LAST : HOLD_LAST)) begin
               r_rcnt     <= '0;
               r_rphase   <= 1'b1;
               r_rep_flag <= 1'b1;
            end else begin
               r_rcnt <= r_rcnt + REP_W'(1);
            end
         end else begin
            r_rcnt   <= '0;
            r_rphase <= 1'b0;
         end
      end
   end

   assign o_rep_flag = r_rep_flag;
`else
   logic w_unused_rep_cfg;
   assign w_unused_rep_cfg = HOLD_CYC[0] ^ REPEAT_CYC[0];
   assign o_rep_flag       = 1'b0;
`endif

endmodule

// File: rtl/key_debounce_array.sv
// N_KEYS independent key debouncers with press/release pulses, debounced level
// and optional hold-to-repeat pulses. Define KEY_REPEAT_EN to build the repeat
// logic; without it Key_Rep_Flag is constant 0 and the port list is unchanged.
module key_debounce_array
   import key_pkg::*;
#(
   parameter int N_KEYS       = 4,
   parameter int DEBOUNCE_CYC = 1000,
   parameter int ACTIVE_LOW   = 1,
   parameter int HOLD_CYC     = 25_000_000,
   parameter int REPEAT_CYC   = 5_000_000
) (
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic [N_KEYS-1:0] Key,
   output logic [N_KEYS-1:0] Key_P_Flag,
   output logic [N_KEYS-1:0] Key_R_Flag,
   output logic [N_KEYS-1:0] Key_State,
   output logic [N_KEYS-1:0] Key_Rep_Flag
);

   for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
      key_debounce_chan #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .ACTIVE_LOW   (ACTIVE_LOW),
         .HOLD_CYC     (HOLD_CYC),
         .REPEAT_CYC   (REPEAT_CYC)
      ) u_chan (
         .i_clk      (Clk),
         .i_rst_n    (Reset_n),
         .i_key      (Key[g]),
         .o_p_flag   (Key_P_Flag[g]),
         .o_r_flag   (Key_R_Flag[g]),
         .o_state    (Key_State[g]),
         .o_rep_flag (Key_Rep_Flag[g])
      );
   end

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array (DEBOUNCE_CYC=8, HOLD_CYC=40, REPEAT_CYC=10).
// Press/release events are queued with their expected edge when the pins are
// driven; a monitor compares every cycle's outputs against the queue.
module tb_key_debounce_array;

   localparam int N    = 4;
   localparam int DEB  = 8;
   localparam int HOLD = 40;
   localparam int REP  = 10;
   localparam int LAT  = DEB + 3;

   logic         Clk     = 1'b0;
   logic         Reset_n = 1'b0;
   logic [N-1:0] Key     = '1;
   logic [N-1:0] Key_P_Flag, Key_R_Flag, Key_State, Key_Rep_Flag;

   typedef struct {
      int         cyc;
      logic [N-1:0] p;
      logic [N-1:0] r;
   } exp_t;

   exp_t q[$];
   int   edge_n   = 0;
   int   checks   = 0;
   int   failures = 0;

   logic [N-1:0] exp_state = '0;
   logic [N-1:0] p_valid   = '0;
   int           p_edge [N];

   key_debounce_array #(
      .N_KEYS       (N),
      .DEBOUNCE_CYC (DEB),
      .ACTIVE_LOW   (1),
      .HOLD_CYC     (HOLD),
      .REPEAT_CYC   (REP)
   ) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .Key          (Key),
      .Key_P_Flag   (Key_P_Flag),
      .Key_R_Flag   (Key_R_Flag),
      .Key_State    (Key_State),
      .Key_Rep_Flag (Key_Rep_Flag)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) edge_n <= edge_n + 1;

   // Per-cycle scoreboard check of every output, sampled 1 time unit after the edge
   always @(posedge Clk) begin
      logic [N-1:0] exp_p, exp_r, exp_rep;
      exp_t e;
      #1;
      exp_p   = '0;
      exp_r   = '0;
      exp_rep = '0;
      if (!Reset_n) begin
         p_valid   = '0;
         exp_state = '0;
      end else begin
         if (q.size() > 0 && q[0].cyc == edge_n) begin
            e     = q.pop_front();
            exp_p = e.p;
            exp_r = e.r;
         end
`ifdef KEY_REPEAT_EN
         for (int ch = 0; ch < N; ch++) begin
            if (p_valid[ch] && (edge_n - p_edge[ch]) >= HOLD &&
                ((edge_n - p_edge[ch] - HOLD) % REP) == 0)
               exp_rep[ch] = 1'b1;
         end
`endif
         for (int ch = 0; ch < N; ch++) begin
            if (exp_p[ch]) begin
               p_valid[ch] = 1'b1;
               p_edge[ch]  = edge_n;
            end
            if (exp_r[ch]) p_valid[ch] = 1'b0;
         end
         exp_state = (exp_state | exp_p) & ~exp_r;
      end
      checks++;
      assert ({Key_P_Flag, Key_R_Flag, Key_Rep_Flag, Key_State} ===
              {exp_p, exp_r, exp_rep, exp_state})
      else begin
         failures++;
         $error("FAIL outputs@edge%0d got p=%b r=%b rep=%b st=%b exp p=%b r=%b rep=%b st=%b",
                edge_n, Key_P_Flag, Key_R_Flag, Key_Rep_Flag, Key_State,
                exp_p, exp_r, exp_rep, exp_state);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic expect_ev(input int c, input logic [N-1:0] pm, input logic [N-1:0] rm);
      exp_t e;
      if (q.size() > 0 && q[q.size()-1].cyc == c) begin
         e   = q[q.size()-1];
         e.p = e.p | pm;
         e.r = e.r | rm;
         q[q.size()-1] = e;
      end else begin
         e.cyc = c;
         e.p   = pm;
         e.r   = rm;
         q.push_back(e);
      end
   endtask

   task automatic key_down(input logic [N-1:0] m);
      Key = Key & ~m;
      expect_ev(edge_n + LAT, m, '0);
   endtask

   task automatic key_up(input logic [N-1:0] m);
      Key = Key | m;
      expect_ev(edge_n + LAT, '0, m);
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial begin
      // reset state
      tick(3);
      chk("rst_p",     32'(Key_P_Flag),   32'h0);
      chk("rst_r",     32'(Key_R_Flag),   32'h0);
      chk("rst_state", 32'(Key_State),    32'h0);
      chk("rst_rep",   32'(Key_Rep_Flag), 32'h0);
      Reset_n = 1'b1;
      tick(5);

      // clean press and release on key 0
      key_down(4'b0001);
      tick(100);
      chk("clean_state", 32'(Key_State[0]), 32'h1);
      key_up(4'b0001);
      tick(20);
      chk("clean_rel_state", 32'(Key_State[0]), 32'h0);

      // bounce on key 1: lows of 3, 5, 7 cycles, then held
      Key[1] = 1'b0; tick(3); Key[1] = 1'b1; tick(2);
      Key[1] = 1'b0; tick(5); Key[1] = 1'b1; tick(2);
      Key[1] = 1'b0; tick(7); Key[1] = 1'b1; tick(2);
      chk("bounce_state", 32'(Key_State[1]), 32'h0);
      key_down(4'b0010);
      tick(30);
      chk("bounce_held", 32'(Key_State[1]), 32'h1);
      key_up(4'b0010);
      tick(20);

      // release glitch on key 2 while held
      key_down(4'b0100);
      tick(20);
      Key[2] = 1'b1; tick(7); Key[2] = 1'b0;
      tick(20);
      chk("glitch_state", 32'(Key_State[2]), 32'h1);
      key_up(4'b0100);
      tick(20);

      // all keys pressed on the same edge
      key_down(4'b1111);
      tick(20);
      chk("simul_state", 32'(Key_State), 32'hF);
      key_up(4'b1111);
      tick(20);

      // reset while key 0 is in the press filter at cnt=5
      Key[0] = 1'b0;
      tick(8);
      Reset_n = 1'b0;
      tick(3);
      chk("midrst_state", 32'(Key_State), 32'h0);
      chk("midrst_p",     32'(Key_P_Flag), 32'h0);
      Reset_n = 1'b1;
      expect_ev(edge_n + LAT, 4'b0001, '0);
      tick(20);
      chk("midrst_after", 32'(Key_State[0]), 32'h1);
      key_up(4'b0001);
      tick(20);

      // long hold on key 3 (repeat pulses only with KEY_REPEAT_EN)
      key_down(4'b1000);
      tick(LAT + 100);
      key_up(4'b1000);
      tick(30);

      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
